cronometro_controle: RTL
========================

# cronometro_controle

Stopwatch timing core. Turns the four board push-buttons into a run/pause/stop/clear state machine, divides the system clock into 0.1 s ticks, and keeps a tenths/seconds count from 000.0 to 999.9. It also provides a lap (display freeze) function. It sits directly upstream of the seven-segment decoder and drives that decoder's `seg`, `dec`, `enable` and `estado_atual` inputs.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_DIV`, default CLK_HZ/10: clocks per 0.1 s tick. Must be ≥ 2.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low. All state clears immediately on assertion.
- `key_inicia_n`  in  1: start/resume button, raw and active-low.
- `key_pausa_n`  in  1: pause button, raw and active-low.
- `key_para_n`  in  1: stop button, raw and active-low.
- `key_zera_n`  in  1: clear button, raw and active-low. In CONTANDO, holding `key_pausa_n` low when `key_zera_n` is pressed makes this a lap press instead of a clear.
- `seg`  out  10: whole seconds, 0..999.
- `dec`  out  4: tenths, 0..9.
- `enable`  out  1: display update enable. 0 means the display holds its last value.
- `estado_atual`  out  3: state code. 0 = ZERADO, 1 = CONTANDO, 2 = PAUSADO, 3 = PARADO. Codes 4..7 never occur.

## Operation
- **Key conditioning**
  - Each key passes through a 2-flop synchronizer and a falling-edge detector, producing a 1-cycle press pulse.
  - A held key generates no further pulses.
  - There is no debounce; the board keys are hardware-debounced.
- **State transitions** (evaluated on press pulses)
  - ZERADO: inicia → CONTANDO.
  - CONTANDO: pausa → PAUSADO; para → PARADO; zera → ZERADO; count overflow → PARADO.
  - PAUSADO: inicia → CONTANDO; para → PARADO; zera → ZERADO.
  - PARADO: zera → ZERADO. All other keys are ignored.
  - Presses with no listed transition are ignored.
  - Simultaneous pulses resolve by priority: zera > para > pausa > inicia.
- **Counting**
  - The prescaler runs only in CONTANDO and counts 0..TICK_DIV−1. At TICK_DIV−1 it emits a tick and wraps to 0.
  - In PAUSADO and PARADO the prescaler holds, so a resume continues the partial tenth.
  - On entering ZERADO the prescaler clears.
  - On a tick: `dec` increments. When `dec` = 9 it wraps to 0 and `seg` increments.
  - A tick at 999.9 does not wrap. The counters hold 999.9 and the state goes to PARADO in the same cycle.
  - Entering ZERADO clears `seg` and `dec` in the same cycle as the state change.
- **Lap (congelado flag)**
  - A zera press while `key_pausa_n` is synchronously low, in CONTANDO only, toggles `congelado` instead of clearing.
  - `enable` = ~congelado.
  - `congelado` clears on entry to ZERADO or PARADO, so the final time is always shown.
  - PAUSADO keeps the current `congelado` value.
  - Counting continues while frozen.

## Timing
- **Reset values:** `seg` = 0, `dec` = 0, `estado_atual` = 0, `enable` = 1, prescaler = 0, `congelado` = 0. Synchronizer flops reset to 1 (released).
- **Key latency:** `key_*_n` low at clk edge N → press pulse high during cycle N+2 → `estado_atual`/`enable` update at edge N+3.
- **Counter outputs:** `seg` and `dec` are registered and update on the edge where the tick is high. First tick comes TICK_DIV cycles after entering CONTANDO from ZERADO.
- **Tick vs. key press in the same cycle:** the tick is applied first, then the transition. Pausa + tick leaves the incremented value held.
- **Zera vs. tick in the same cycle:** zera wins; the result is 000.0.
- **Reset asserted mid-count:** all outputs return to their reset values asynchronously.

## Structure
- **Package `cronometro_pkg`:** state encoding constants ZERADO/CONTANDO/PAUSADO/PARADO as 3-bit values, plus `SEG_MAX` = 999 and `DEC_MAX` = 9.
- **Sub-module `detector_borda`:** 2-flop synchronizer plus falling-edge pulse, with ports `clk`, `rst_n`, `key_n`, `pulso`. Instantiated four times.
- **Top level:** the FSM, prescaler, BCD-style counters and the lap flag.

## Test plan
All scenarios use `TICK_DIV` = 10.

1. **Reset:** reset, then release → `seg` = 0, `dec` = 0, `estado_atual` = 0, `enable` = 1. Pulse inicia → `estado_atual` = 1 at edge N+3; `dec` = 1 exactly 10 cycles later.
2. **Count, pause, resume:** run 125 ticks → `seg` = 12, `dec` = 5. Pausa → `estado_atual` = 2 and the count holds for 100 cycles. Inicia → counting resumes with the preserved prescaler phase.
3. **Overflow:** preload by running to 999.8, then one tick → 999.9. Next tick → still 999.9, `estado_atual` = 3. Inicia and pausa are ignored; zera → 000.0, state 0.
4. **Lap:** in CONTANDO, hold pausa and press zera → `enable` = 0 while `seg`/`dec` keep advancing. Repeat → `enable` = 1. Lap, then para → `enable` = 1, state 3.
5. **Simultaneous keys:** press para and zera together in CONTANDO → state 0, count 000.0. Press inicia and pausa together in PAUSADO → stays PAUSADO.
6. **Async reset mid-count:** drop `rst_n` mid-count at 37.4, between edges → outputs reset immediately. A held key across reset release produces no pulse.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch core: state codes and count limits.
package cronometro_pkg;

    typedef enum logic [2:0] {
        ZERADO   = 3'd0,
        CONTANDO = 3'd1,
        PAUSADO  = 3'd2,
        PARADO   = 3'd3
    } estado_t;

    localparam logic [9:0] SEG_MAX = 10'd999;
    localparam logic [3:0] DEC_MAX = 4'd9;

endpackage

// File: rtl/cronometro_controle_detector_borda.sv
// Key conditioner: 2-flop synchronizer plus registered falling-edge pulse.
// Pulses are suppressed until the synchronizer holds only post-reset samples.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulso
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_pulso;
    logic [2:0] r_vld;

    // r_vld tracks which stages carry real key samples, so a key held
    // through reset release never looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_vld   <= 3'b000;
            r_pulso <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_vld   <= {r_vld[1:0], 1'b1};
            r_pulso <= r_vld[2] & r_prev & ~r_sync2;
        end
    end

    assign pulso = r_pulso;

endmodule

// File: rtl/cronometro_controle.sv
// Stopwatch control: key FSM, 0.1 s prescaler, seconds/tenths counters and
// lap (display freeze) flag.
module cronometro_controle #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_DIV = CLK_HZ / 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_inicia_n,
    input  logic       key_pausa_n,
    input  logic       key_para_n,
    input  logic       key_zera_n,
    output logic [9:0] seg,
    output logic [3:0] dec,
    output logic       enable,
    output logic [2:0] estado_atual
);

    import cronometro_pkg::*;

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [3:0] w_keys_n;
    logic [3:0] w_pulso;
    logic       w_zera;
    logic       w_para;
    logic       w_pausa;
    logic       w_inicia;
    logic       w_tick;
    logic       w_overflow;
    logic       w_lap;
    estado_t    w_base;
    estado_t    w_estado_next;

    estado_t       r_estado;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_seg;
    logic [3:0]    r_dec;
    logic          r_congelado;
    logic [2:0]    r_pausa_lvl;

    assign w_keys_n = {key_zera_n, key_para_n, key_pausa_n, key_inicia_n};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            detector_borda u_det (
                .clk   (clk),
                .rst_n (rst_n),
                .key_n (w_keys_n[gi]),
                .pulso (w_pulso[gi])
            );
        end
    endgenerate

    // Strict priority: only the highest-priority pulse is considered at all.
    assign w_zera   = w_pulso[3];
    assign w_para   = w_pulso[2] & ~w_pulso[3];
    assign w_pausa  = w_pulso[1] & ~w_pulso[2] & ~w_pulso[3];
    assign w_inicia = w_pulso[0] & ~w_pulso[1] & ~w_pulso[2] & ~w_pulso[3];

    assign w_tick     = (r_estado == CONTANDO) && (r_presc == TICK_LAST);
    assign w_overflow = w_tick && (r_seg == SEG_MAX) && (r_dec == DEC_MAX);
    // The tick acts first; key transitions start from the post-tick state.
    assign w_base     = w_overflow ? PARADO : r_estado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ZERADO;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    always_comb begin
        w_estado_next = w_base;
        w_lap         = 1'b0;
        case (w_base)
            ZERADO: begin
                if (w_inicia) w_estado_next = CONTANDO;
            end
            CONTANDO: begin
                if (w_zera) begin
                    if (!r_pausa_lvl[2]) w_lap = 1'b1;
                    else                 w_estado_next = ZERADO;
                end else if (w_para) begin
                    w_estado_next = PARADO;
                end else if (w_pausa) begin
                    w_estado_next = PAUSADO;
                end
            end
            PAUSADO: begin
                if (w_zera)        w_estado_next = ZERADO;
                else if (w_para)   w_estado_next = PARADO;
                else if (w_inicia) w_estado_next = CONTANDO;
            end
            PARADO: begin
                if (w_zera) w_estado_next = ZERADO;
            end
            default: w_estado_next = ZERADO;
        endcase
    end

    // Pausa level delayed to line up with the registered press pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pausa_lvl <= 3'b111;
        end else begin
            r_pausa_lvl <= {r_pausa_lvl[1:0], key_pausa_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_seg       <= 10'd0;
            r_dec       <= 4'd0;
            r_congelado <= 1'b0;
        end else begin
            if (w_estado_next == ZERADO) begin
                r_presc <= '0;
                r_seg   <= 10'd0;
                r_dec   <= 4'd0;
            end else begin
                if (r_estado == CONTANDO) begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                end
                if (w_tick && !w_overflow) begin
                    if (r_dec == DEC_MAX) begin
                        r_dec <= 4'd0;
                        r_seg <= r_seg + 10'd1;
                    end else begin
                        r_dec <= r_dec + 4'd1;
                    end
                end
            end
            if (w_estado_next == ZERADO || w_estado_next == PARADO) begin
                r_congelado <= 1'b0;
            end else if (w_lap) begin
                r_congelado <= ~r_congelado;
            end
        end
    end

    assign seg          = r_seg;
    assign dec          = r_dec;
    assign enable       = ~r_congelado;
    assign estado_atual = r_estado;

endmodule
